// File: rtl/ysyx_22040237_lsu_mc.sv
// rtl/ysyx_22040237_lsu_mc.sv - multi-cycle load/store unit with request/response memory port
// Optional misaligned-access trap enabled by defining YSYX_22040237_MISALIGN_CHK_EN.
module ysyx_22040237_lsu_mc #(
  parameter int REG_WIDTH = 64,
  parameter int OFS_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   rd_wr_en_i,
  input  logic [4:0]             rd_idx_i,
  input  logic [REG_WIDTH-1:0]   alu_res_i,
  input  logic                   mem_ren_i,
  input  logic                   mem_wen_i,
  input  logic [1:0]             mem_size_i,
  input  logic                   mem_unsigned_i,
  input  logic [REG_WIDTH-1:0]   store_data_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_we_o,
  output logic [REG_WIDTH-1:0]   mem_req_addr_o,
  output logic [REG_WIDTH-1:0]   mem_req_wdata_o,
  output logic [REG_WIDTH/8-1:0] mem_req_wmask_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [REG_WIDTH-1:0]   mem_rsp_rdata_i,
  output logic                   out_valid,
  output logic                   rd_wr_en_o,
  output logic [4:0]             rd_idx_o,
  output logic [REG_WIDTH-1:0]   rd_data_o,
  output logic                   misalign_o
);

  localparam int NB = REG_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state, state_n;
  logic [OFS_W-1:0] off_q;
  logic [1:0]       size_q;
  logic             uns_q;

  logic             accept;
  logic             is_mem_i;
  logic [1:0]       size_i_eff;
  logic [OFS_W-1:0] off_i;
  logic             misal_i;
  logic [2*NB-1:0]  mask_full;
  logic [REG_WIDTH-1:0] rsp_shifted;

  // A 32-bit datapath has no doubleword accesses; fold size 3 onto size 2.
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (REG_WIDTH == 32 && s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [NB-1:0] byte_ones(input logic [1:0] s);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (i < (1 << int'(s)));
    return r;
  endfunction

  function automatic logic [REG_WIDTH-1:0] load_ext(input logic [REG_WIDTH-1:0] sh,
                                                    input logic [1:0] s,
                                                    input logic uns);
    logic [REG_WIDTH-1:0] r;
    logic msb;
    int nbits;
    nbits = 8 << int'(s);
    msb = 1'b0;
    for (int i = 0; i < REG_WIDTH; i++) if (i == nbits - 1) msb = sh[i];
    for (int i = 0; i < REG_WIDTH; i++) r[i] = (i < nbits) ? sh[i] : (msb & ~uns);
    return r;
  endfunction

  assign in_ready        = (state == IDLE);
  assign mem_req_valid_o = (state == REQ);
  assign out_valid       = (state == DONE);

  assign accept      = in_valid & in_ready;
  assign is_mem_i    = mem_ren_i | mem_wen_i;
  assign size_i_eff  = eff_size(mem_size_i);
  assign off_i       = alu_res_i[OFS_W-1:0];
  // Bytes past the end of the word fall off the top and are simply not written.
  assign mask_full   = {{NB{1'b0}}, byte_ones(size_i_eff)} << off_i;
  assign rsp_shifted = mem_rsp_rdata_i >> {off_q, 3'b000};

`ifdef YSYX_22040237_MISALIGN_CHK_EN
  always_comb begin
    misal_i = 1'b0;
    case (size_i_eff)
      2'd0:    misal_i = 1'b0;
      2'd1:    misal_i = alu_res_i[0];
      2'd2:    misal_i = |alu_res_i[1:0];
      default: misal_i = |alu_res_i[2:0];
    endcase
    misal_i = misal_i & is_mem_i;
  end
`else
  assign misal_i = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = (!is_mem_i || misal_i) ? DONE : REQ;
      REQ:  if (mem_req_ready_i) state_n = mem_req_we_o ? DONE : WAIT;
      WAIT: if (mem_rsp_valid_i) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      off_q           <= '0;
      size_q          <= '0;
      uns_q           <= 1'b0;
      mem_req_we_o    <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_wdata_o <= '0;
      mem_req_wmask_o <= '0;
      rd_wr_en_o      <= 1'b0;
      rd_idx_o        <= '0;
      rd_data_o       <= '0;
      misalign_o      <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        off_q           <= off_i;
        size_q          <= size_i_eff;
        uns_q           <= mem_unsigned_i;
        mem_req_we_o    <= mem_wen_i;
        mem_req_addr_o  <= {alu_res_i[REG_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
        mem_req_wdata_o <= store_data_i << {off_i, 3'b000};
        mem_req_wmask_o <= mask_full[NB-1:0];
        rd_wr_en_o      <= rd_wr_en_i & ~mem_wen_i & ~misal_i;
        rd_idx_o        <= rd_idx_i;
        rd_data_o       <= alu_res_i;
        misalign_o      <= misal_i;
      end
      if (state == WAIT && mem_rsp_valid_i) rd_data_o <= load_ext(rsp_shifted, size_q, uns_q);
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu_mc.sv
// tb/tb_ysyx_22040237_lsu_mc.sv - randomized self-checking bench for ysyx_22040237_lsu_mc
// Expectations adapt to YSYX_22040237_MISALIGN_CHK_EN when defined.
module tb_ysyx_22040237_lsu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] alu_res_i;
  logic        mem_ren_i, mem_wen_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [63:0] store_data_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_rdata_i;
  logic        out_valid, rd_wr_en_o, misalign_o;
  logic [4:0]  rd_idx_o;
  logic [63:0] rd_data_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] last_rd;

  always #5 clk = ~clk;

  ysyx_22040237_lsu_mc #(.REG_WIDTH(64), .OFS_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i), .alu_res_i(alu_res_i),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .store_data_i(store_data_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .out_valid(out_valid), .rd_wr_en_o(rd_wr_en_o), .rd_idx_o(rd_idx_o),
    .rd_data_o(rd_data_o), .misalign_o(misalign_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: pick 2^size bytes starting at the offset of the returned word, then extend.
  function automatic logic [63:0] ld_model(input logic [63:0] rdata, input logic [63:0] addr,
                                           input int size, input bit uns);
    logic [127:0] v, m;
    int nbytes, off;
    nbytes = 1 << size;
    off = int'(addr % 8);
    v = {64'd0, rdata} >> (8 * off);
    m = (128'd1 << (8 * nbytes)) - 128'd1;
    v = v & m;
    if (!uns && v[8*nbytes-1]) v = v | ~m;
    return v[63:0];
  endfunction

  function automatic logic [7:0] mask_model(input logic [63:0] addr, input int size);
    logic [15:0] m;
    m = ((16'd1 << (1 << size)) - 16'd1) << (addr % 8);
    return m[7:0];
  endfunction

  function automatic logic [63:0] wdata_model(input logic [63:0] data, input logic [63:0] addr);
    logic [127:0] v;
    v = {64'd0, data} << (8 * (addr % 8));
    return v[63:0];
  endfunction

  task automatic scramble_inputs;
    rd_wr_en_i     = 1'($urandom);
    rd_idx_i       = 5'($urandom);
    alu_res_i      = {$urandom, $urandom};
    mem_ren_i      = 1'($urandom);
    mem_wen_i      = 1'($urandom);
    mem_size_i     = 2'($urandom);
    mem_unsigned_i = 1'($urandom);
    store_data_i   = {$urandom, $urandom};
  endtask

  task automatic wait_ready;
    int k = 0;
    while (!in_ready && k < 20) begin
      tick;
      k++;
    end
    check("in_ready_timeout", in_ready, 1'b1);
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 load+store (treated as store)
  task automatic run_op(input int kind, input logic [63:0] addr, input logic [63:0] data,
                        input int size, input bit uns, input bit rden, input logic [4:0] idx,
                        input int rdy_dly, input int rsp_dly, input logic [63:0] rdata);
    bit ren, wen, is_mem, misal;
    logic [63:0] exp_addr;
    ren = (kind == 1 || kind == 3);
    wen = (kind >= 2);
    is_mem = ren | wen;
    misal = 1'b0;
`ifdef YSYX_22040237_MISALIGN_CHK_EN
    misal = is_mem && ((addr % (64'd1 << size)) != 0);
`endif
    exp_addr = addr & ~64'd7;
    wait_ready;
    in_valid = 1'b1;
    rd_wr_en_i = rden; rd_idx_i = idx; alu_res_i = addr;
    mem_ren_i = ren; mem_wen_i = wen; mem_size_i = 2'(size);
    mem_unsigned_i = uns; store_data_i = data;
    tick;
    in_valid = 1'b0;
    scramble_inputs;
    if (!is_mem || misal) begin
      check("short_ov", out_valid, 1'b1);
      check("short_no_req", mem_req_valid_o, 1'b0);
      if (!is_mem) check("alu_data", rd_data_o, addr);
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check("req_valid", mem_req_valid_o, 1'b1);
        check("req_addr", mem_req_addr_o, exp_addr);
        check("req_we", mem_req_we_o, wen);
        if (wen) begin
          check("req_wmask", mem_req_wmask_o, mask_model(addr, size));
          check("req_wdata", wdata_model(data, addr) & mem_req_wdata_o,
                wdata_model(data, addr));
          check("req_wdata_full", mem_req_wdata_o, wdata_model(data, addr));
        end
        check("req_no_ov", out_valid, 1'b0);
        if (i == rdy_dly) mem_req_ready_i = 1'b1;
        tick;
      end
      mem_req_ready_i = 1'b0;
      if (!wen) begin
        for (int j = 0; j < rsp_dly; j++) begin
          mem_rsp_rdata_i = {$urandom, $urandom};
          check("wait_no_ov", out_valid, 1'b0);
          check("wait_no_req", mem_req_valid_o, 1'b0);
          tick;
        end
        mem_rsp_rdata_i = rdata;
        mem_rsp_valid_i = 1'b1;
        tick;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_rdata_i = {$urandom, $urandom};
      end
      check("mem_ov", out_valid, 1'b1);
      if (!wen) check("load_data", rd_data_o, ld_model(rdata, addr, size, uns));
    end
    check("misalign", misalign_o, misal);
    check("rd_wr_en", rd_wr_en_o, (wen || misal) ? 1'b0 : rden);
    check("rd_idx", rd_idx_o, idx);
    last_rd = rd_data_o;
    tick;
    check("ov_once", out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_rdata_i = '0;
    scramble_inputs;
    tick;
    tick;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ov", out_valid, 1'b0);
    check("rst_req", mem_req_valid_o, 1'b0);
    check("rst_rd_data", rd_data_o, 64'd0);
    check("rst_wmask", mem_req_wmask_o, 8'd0);
    rst = 1'b1;
    tick;

    run_op(0, 64'h1234, 64'd0, 0, 1'b0, 1'b1, 5'd5, 0, 0, 64'd0);
    check("alu_1234", last_rd, 64'h1234);
    run_op(1, 64'h8000_0003, 64'd0, 0, 1'b0, 1'b1, 5'd9, 3, 1, 64'h0000_0000_8000_0000);
    check("lb_sext", last_rd, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1, 64'h8000_0003, 64'd0, 0, 1'b1, 1'b1, 5'd9, 3, 0, 64'h0000_0000_8000_0000);
    check("lbu_zext", last_rd, 64'h80);
    run_op(2, 64'h8000_0002, 64'hABCD, 1, 1'b0, 1'b1, 5'd3, 1, 0, 64'd0);
    run_op(1, 64'h8000_0002, 64'd0, 2, 1'b0, 1'b1, 5'd4, 0, 2, 64'h1122_3344_5566_7788);
    run_op(3, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 3, 1'b0, 1'b1, 5'd6, 0, 0, 64'd0);

    for (int n = 0; n < 60; n++) begin
      int size;
      logic [63:0] addr;
      size = $urandom_range(0, 3);
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << size) - 64'd1);
      run_op($urandom_range(0, 3), addr, {$urandom, $urandom}, size, 1'($urandom),
             1'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             {$urandom, $urandom});
    end

    // Reset while waiting on a load response.
    wait_ready;
    in_valid = 1'b1; rd_wr_en_i = 1'b1; rd_idx_i = 5'd7; alu_res_i = 64'h8000_0040;
    mem_ren_i = 1'b1; mem_wen_i = 1'b0; mem_size_i = 2'd3; mem_unsigned_i = 1'b0;
    tick;
    in_valid = 1'b0;
    mem_req_ready_i = 1'b1;
    tick;
    mem_req_ready_i = 1'b0;
    check("wait_before_rst", out_valid, 1'b0);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_ov", out_valid, 1'b0);
    check("mid_rst_req", mem_req_valid_o, 1'b0);
    check("mid_rst_rd_data", rd_data_o, 64'd0);
    check("mid_rst_rd_idx", rd_idx_o, 5'd0);
    check("mid_rst_rd_wr_en", rd_wr_en_o, 1'b0);
    check("mid_rst_misalign", misalign_o, 1'b0);
    check("mid_rst_wmask", mem_req_wmask_o, 8'd0);
    check("mid_rst_wdata", mem_req_wdata_o, 64'd0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick;
    mem_rsp_valid_i = 1'b0;
    check("late_rsp_ov", out_valid, 1'b0);
    check("late_rsp_data", rd_data_o, 64'd0);
    tick;
    check("late_rsp_ov2", out_valid, 1'b0);

    run_op(1, 64'h8000_0044, 64'd0, 1, 1'b1, 1'b1, 5'd8, 0, 0, 64'h0000_BEEF_0000_0000);
    check("post_rst_lhu", last_rd, 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_lsu_mc.md
YSYX_22040237_LSU_MC -- requirements
Module: ysyx_22040237_lsu_mc

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, meaning data and address width (32 or 64).
REQ-002 SHALL have parameter OFS_W, default 3, meaning byte-offset bits, log2(REG_WIDTH/8).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  and in_ready  out  1  for the upstream handshake.
REQ-006 SHALL have port rd_wr_en_i  in  1  and rd_idx_i  in  5  for the destination register.
REQ-007 SHALL have port alu_res_i  in  REG_WIDTH  carrying the ALU result or the memory address.
REQ-008 SHALL have ports mem_ren_i  in  1, mem_wen_i  in  1, mem_size_i  in  2 (0=B,1=H,2=W,3=D) and mem_unsigned_i  in  1.
REQ-009 SHALL have port store_data_i  in  REG_WIDTH  carrying unshifted store data.
REQ-010 SHALL have ports mem_req_valid_o  out  1, mem_req_ready_i  in  1, mem_req_we_o  out  1, mem_req_addr_o  out  REG_WIDTH, mem_req_wdata_o  out  REG_WIDTH and mem_req_wmask_o  out  REG_WIDTH/8.
REQ-011 SHALL have ports mem_rsp_valid_i  in  1 and mem_rsp_rdata_i  in  REG_WIDTH  carrying the aligned word containing the address.
REQ-012 SHALL have ports out_valid  out  1, rd_wr_en_o  out  1, rd_idx_o  out  5, rd_data_o  out  REG_WIDTH and misalign_o  out  1.

Function
REQ-013 SHALL implement FSM IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 SHALL, on accept (in_valid&in_ready), register all inputs; with mem_ren_i=mem_wen_i=0, SHALL go IDLE->DONE and set rd_data_o=alu_res_i (latency 1).
REQ-015 SHALL, on accepting a load or store, go IDLE->REQ and hold mem_req_valid_o=1 with stable request fields until mem_req_ready_i=1.
REQ-016 SHALL, on the REQ handshake, go to WAIT for a load and to DONE for a store (no response expected for stores).
REQ-017 SHALL, in WAIT, ignore rsp data until mem_rsp_valid_i=1, then capture extended load data and go to DONE.
REQ-018 SHALL assert out_valid for exactly one cycle in DONE, then return to IDLE; mem_rsp_valid_i outside WAIT is ignored.
REQ-019 SHALL drive mem_req_addr_o as the address with low OFS_W bits cleared.
REQ-020 SHALL shift store data left by 8*addr[OFS_W-1:0] and set wmask bits for the 2^size bytes starting at that offset.
REQ-021 SHALL, for loads, shift rdata right by 8*offset, take 2^size bytes, then zero-extend if mem_unsigned_i=1, else sign-extend to REG_WIDTH.
REQ-022 SHALL treat size 3 as size 2 when REG_WIDTH=32.
REQ-023 SHALL force rd_wr_en_o=0 for stores; loads and ALU ops pass rd_wr_en_i/rd_idx_i through.
REQ-024 SHALL, if mem_ren_i and mem_wen_i are both 1, treat the op as a store.

Reset
REQ-025 SHALL, when rst=0 at a clock edge, enter IDLE and clear out_valid, mem_req_valid_o, rd_wr_en_o, rd_idx_o, rd_data_o, misalign_o, wmask and wdata to 0, regardless of state.
REQ-026 SHALL abandon any in-flight request on reset mid-operation without producing out_valid.

Configuration
REQ-027 SHALL, with YSYX_22040237_MISALIGN_CHK_EN defined, flag an access whose address is not a multiple of 2^size: skip REQ/WAIT, go IDLE->DONE, assert misalign_o with out_valid, force rd_wr_en_o=0.
REQ-028 SHALL, without YSYX_22040237_MISALIGN_CHK_EN, tie misalign_o to 0 and issue misaligned accesses with the mask clipped to the word.

Verification
REQ-029 ALU op alu_res_i=0x1234, rd_idx_i=5 -> out_valid one cycle later, rd_data_o=0x1234, rd_idx_o=5.
REQ-030 LB addr 0x8000_0003, rdata 0x0000_0000_8000_0000 with ready delayed 3 cycles -> req held 3 cycles, rd_data_o=0xFFFF_FFFF_FFFF_FF80 (LBU: 0x80).
REQ-031 SH addr 0x8000_0002, data 0xABCD -> wdata 0x0000_0000_ABCD_0000, wmask 0x0C, rd_wr_en_o=0.
REQ-032 LW addr 0x8000_0002 with macro -> no mem_req_valid_o, misalign_o=1, out_valid=1; without macro -> request issued, misalign_o=0.
REQ-033 rst=0 asserted in WAIT -> next cycle IDLE, in_ready=1, all outputs 0; late mem_rsp_valid_i ignored.
